// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared ALU op codes, writeback constants and
// memory-stage FSM encodings, plus op-class helper functions.
package mem_access_pkg;

    typedef logic [7:0] alu_op_bus_t;

    localparam alu_op_bus_t ALU_NOP_OP = 8'h00;
    localparam alu_op_bus_t ALU_ADD_OP = 8'h01;
    localparam alu_op_bus_t ALU_SUB_OP = 8'h02;
    localparam alu_op_bus_t ALU_AND_OP = 8'h03;
    localparam alu_op_bus_t ALU_OR_OP  = 8'h04;
    localparam alu_op_bus_t ALU_LB_OP  = 8'h10;
    localparam alu_op_bus_t ALU_LH_OP  = 8'h11;
    localparam alu_op_bus_t ALU_LW_OP  = 8'h12;
    localparam alu_op_bus_t ALU_LBU_OP = 8'h13;
    localparam alu_op_bus_t ALU_LHU_OP = 8'h14;
    localparam alu_op_bus_t ALU_SB_OP  = 8'h18;
    localparam alu_op_bus_t ALU_SH_OP  = 8'h19;
    localparam alu_op_bus_t ALU_SW_OP  = 8'h1A;

    localparam logic        Enable     = 1'b1;
    localparam logic        Disable    = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NopRegAddr = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

    function automatic logic is_load(alu_op_bus_t op);
        return (op == ALU_LB_OP) || (op == ALU_LH_OP) ||
               (op == ALU_LW_OP) || (op == ALU_LBU_OP) ||
               (op == ALU_LHU_OP);
    endfunction

    function automatic logic is_store(alu_op_bus_t op);
        return (op == ALU_SB_OP) || (op == ALU_SH_OP) ||
               (op == ALU_SW_OP);
    endfunction

    // Index of the final byte of the transfer (byte count minus one).
    function automatic logic [1:0] last_byte(alu_op_bus_t op);
        logic [1:0] r;
        r = 2'd0;
        unique case (1'b1)
            (op == ALU_LW_OP) || (op == ALU_SW_OP): r = 2'd3;
            (op == ALU_LH_OP) || (op == ALU_LHU_OP) ||
            (op == ALU_SH_OP): r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// load_extend: sign/zero extension of an assembled load word.
// Ports: aluop (load op), asm_word (assembled bytes), ext_word (result).
module load_extend
    import mem_access_pkg::*;
(
    input  alu_op_bus_t aluop,
    input  logic [31:0] asm_word,
    output logic [31:0] ext_word
);

    always_comb begin
        ext_word = asm_word;
        unique case (1'b1)
            (aluop == ALU_LB_OP):
                ext_word = {{24{asm_word[7]}}, asm_word[7:0]};
            (aluop == ALU_LH_OP):
                ext_word = {{16{asm_word[15]}}, asm_word[15:0]};
            (aluop == ALU_LBU_OP):
                ext_word = {24'h0, asm_word[7:0]};
            (aluop == ALU_LHU_OP):
                ext_word = {16'h0, asm_word[15:0]};
            default:
                ext_word = asm_word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: byte-serial load/store stage with pipeline stall request.
// Ports: EX/MEM inputs, byte memory port (req/we/addr/wdata/rdata/ack),
// stallreq_o, and the writeback triple wreg_o/waddr_o/wdata_o.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        dclk,
    input  logic        rst,
    input  alu_op_bus_t aluop_i,
    input  logic        wreg_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] alurslt_i,
    input  logic [31:0] sdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stallreq_o,
    output logic        wreg_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o
);

    mem_state_t  state;
    logic [1:0]  k;
    logic [31:0] asm_q;
    logic [31:0] ext_word;
    logic        ld_op;
    logic        st_op;

    assign ld_op = is_load(aluop_i);
    assign st_op = is_store(aluop_i);

    load_extend u_ext (
        .aluop    (aluop_i),
        .asm_word (asm_q),
        .ext_word (ext_word)
    );

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= 2'd0;
            asm_q <= ZeroWord;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ld_op || st_op) begin
                        state <= ST_ACCESS;
                        k     <= 2'd0;
                        asm_q <= ZeroWord;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack_i) begin
                        if (ld_op)
                            asm_q[{k, 3'b000} +: 8] <= mem_rdata_i;
                        if (k == last_byte(aluop_i))
                            state <= ST_DONE;
                        else
                            k <= k + 2'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are combinational so the stall is raised in the same
    // cycle a memory op shows up; reset gates them to idle values.
    always_comb begin
        mem_req_o   = Disable;
        mem_we_o    = Disable;
        mem_addr_o  = ZeroWord;
        mem_wdata_o = 8'h00;
        stallreq_o  = Disable;
        wreg_o      = Disable;
        waddr_o     = NopRegAddr;
        wdata_o     = ZeroWord;
        if (!rst) begin
            unique case (state)
                ST_IDLE: begin
                    if (ld_op || st_op) begin
                        stallreq_o = Enable;
                    end else begin
                        wreg_o  = wreg_i;
                        waddr_o = waddr_i;
                        wdata_o = alurslt_i;
                    end
                end
                ST_ACCESS: begin
                    stallreq_o = Enable;
                    mem_req_o  = Enable;
                    mem_we_o   = st_op;
                    mem_addr_o = alurslt_i + {30'd0, k};
                    if (st_op)
                        mem_wdata_o = sdata_i[{k, 3'b000} +: 8];
                end
                ST_DONE: begin
                    if (ld_op) begin
                        wreg_o  = wreg_i;
                        waddr_o = waddr_i;
                        wdata_o = ext_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against
// a byte-addressed memory model and a word-level load/store reference.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        dclk;
    logic        rst;
    alu_op_bus_t aluop;
    logic        wreg_i;
    logic [4:0]  waddr_i;
    logic [31:0] alurslt;
    logic [31:0] sdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        stallreq;
    logic        wreg_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    mem_access dut (
        .dclk        (dclk),
        .rst         (rst),
        .aluop_i     (aluop),
        .wreg_i      (wreg_i),
        .waddr_i     (waddr_i),
        .alurslt_i   (alurslt),
        .sdata_i     (sdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .stallreq_o  (stallreq),
        .wreg_o      (wreg_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem [logic [31:0]];

    // observations from one operation
    int          o_stall;
    int          o_leak;
    int          o_unstable;
    bit          o_done;
    logic        o_wreg;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [31:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    logic        obs_we[$];

    function automatic logic [7:0] mem_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic int nbytes(alu_op_bus_t op);
        if (op == ALU_LW_OP || op == ALU_SW_OP) return 4;
        if (op == ALU_LH_OP || op == ALU_LHU_OP || op == ALU_SH_OP) return 2;
        if (is_load(op) || is_store(op)) return 1;
        return 0;
    endfunction

    // Reference: little-endian word from memory, then extended.
    function automatic logic [31:0] ref_load(alu_op_bus_t op,
                                             logic [31:0] base);
        logic [31:0] v;
        int b;
        v = 0;
        for (int i = 0; i < nbytes(op); i++)
            v = v | (32'(mem_rd(base + 32'(i))) << (8 * i));
        b = int'(v);
        if (op == ALU_LB_OP) begin
            b = b & 255;
            if (b >= 128) b = b - 256;
        end else if (op == ALU_LH_OP) begin
            b = b & 65535;
            if (b >= 32768) b = b - 65536;
        end
        return 32'(b);
    endfunction

    // Drives one op from a negedge; acts as the memory responder
    // with ws wait states per byte; returns at the next negedge
    // after the first cycle with stallreq low.
    task automatic run_op(input alu_op_bus_t op, input logic [31:0] base,
                          input logic [31:0] sd, input logic wr,
                          input logic [4:0] wa, input int ws,
                          input bit noise);
        int waitc;
        logic [31:0] pa;
        logic pw;
        logic [7:0] pd;
        aluop = op; alurslt = base; sdata = sd;
        wreg_i = wr; waddr_i = wa;
        o_stall = 0; o_leak = 0; o_unstable = 0; o_done = 0;
        o_wreg = 0; o_waddr = 0; o_wdata = 0;
        obs_addr.delete(); obs_data.delete(); obs_we.delete();
        waitc = 0; pa = 0; pw = 0; pd = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (stallreq) begin
                o_stall++;
                if (wreg_o !== 1'b0) o_leak++;
            end else if (mem_req !== 1'b0) begin
                o_leak++;
            end
            if (mem_req === 1'b1) begin
                if (waitc > 0 && (mem_addr !== pa || mem_we !== pw ||
                                  mem_wdata !== pd))
                    o_unstable++;
                pa = mem_addr; pw = mem_we; pd = mem_wdata;
                if (waitc >= ws) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_rd(mem_addr);
                    obs_addr.push_back(mem_addr);
                    obs_we.push_back(mem_we);
                    obs_data.push_back(mem_we ? mem_wdata : mem_rdata);
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    waitc = 0;
                end else begin
                    mem_ack = 1'b0;
                    waitc++;
                end
            end else begin
                mem_ack = noise ? 1'($urandom) : 1'b0;
                mem_rdata = 8'($urandom);
            end
            if (stallreq === 1'b0) begin
                o_done = 1;
                o_wreg = wreg_o; o_waddr = waddr_o; o_wdata = wdata_o;
                @(negedge dclk);
                mem_ack = 1'b0;
                return;
            end
            @(negedge dclk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        aluop = ALU_ADD_OP; wreg_i = 1'b1; waddr_i = 5'd7;
        alurslt = 32'hDEAD_BEEF; sdata = 32'h1; mem_ack = 1'b1;
        mem_rdata = 8'h5A;
        #2;
        nvec++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 42'd0) begin
            nerr++;
            $display("FAIL reset_mem got req=%b we=%b a=%h d=%h want 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        nvec++;
        if ({stallreq, wreg_o, waddr_o, wdata_o} !==
            {1'b0, 1'b0, NopRegAddr, ZeroWord}) begin
            nerr++;
            $display("FAIL reset_wb got st=%b w=%b a=%h d=%h want 0/0/%h/%h",
                     stallreq, wreg_o, waddr_o, wdata_o, NopRegAddr, ZeroWord);
        end
        aluop = ALU_LW_OP;
        #1;
        nvec++;
        if (stallreq !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ld_stall got %b want 0", stallreq);
        end
        mem_ack = 1'b0;
        @(negedge dclk);
        @(negedge dclk);
        aluop = ALU_NOP_OP;
        rst = 1'b0;
        @(negedge dclk);
    endtask

    task automatic test_alu_pass();
        run_op(ALU_ADD_OP, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 0, 1'b0);
        nvec++;
        if (o_stall !== 0 || o_done !== 1'b1) begin
            nerr++;
            $display("FAIL add_stall got %0d want 0", o_stall);
        end
        nvec++;
        if ({o_wreg, o_waddr, o_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
            nerr++;
            $display("FAIL add_wb got %b/%0d/%h want 1/5/00001234",
                     o_wreg, o_waddr, o_wdata);
        end
        nvec++;
        if (obs_addr.size() != 0 || o_leak != 0) begin
            nerr++;
            $display("FAIL add_noreq got %0d bytes %0d leaks want 0",
                     obs_addr.size(), o_leak);
        end
    endtask

    task automatic test_lw();
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56;
        mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        run_op(ALU_LW_OP, 32'h100, 32'h0, 1'b1, 5'd9, 0, 1'b0);
        nvec++;
        if (o_stall != 5 || !o_done) begin
            nerr++;
            $display("FAIL lw_stall got %0d want 5", o_stall);
        end
        nvec++;
        if ({o_wreg, o_waddr, o_wdata} !== {1'b1, 5'd9, 32'h1234_5678}) begin
            nerr++;
            $display("FAIL lw_wb got %b/%0d/%h want 1/9/12345678",
                     o_wreg, o_waddr, o_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (obs_addr.size() != 4 || obs_addr[i] !== 32'h100 + 32'(i) ||
                obs_we[i] !== 1'b0) begin
                nerr++;
                $display("FAIL lw_addr%0d got %h want %h", i,
                         obs_addr[i], 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_lb_lbu();
        mem[32'h20] = 8'h80;
        run_op(ALU_LB_OP, 32'h20, 32'h0, 1'b1, 5'd3, 1, 1'b0);
        nvec++;
        if (o_wdata !== 32'hFFFF_FF80 || o_stall != 3) begin
            nerr++;
            $display("FAIL lb_data got %h st=%0d want ffffff80 st=3",
                     o_wdata, o_stall);
        end
        run_op(ALU_LBU_OP, 32'h20, 32'h0, 1'b1, 5'd3, 0, 1'b0);
        nvec++;
        if (o_wdata !== 32'h0000_0080 || o_stall != 2) begin
            nerr++;
            $display("FAIL lbu_data got %h st=%0d want 00000080 st=2",
                     o_wdata, o_stall);
        end
    endtask

    task automatic test_sh_wait();
        run_op(ALU_SH_OP, 32'h7FF, 32'hAABB_CCDD, 1'b1, 5'd4, 2, 1'b0);
        nvec++;
        if (o_stall != 7) begin
            nerr++;
            $display("FAIL sh_stall got %0d want 7", o_stall);
        end
        nvec++;
        if ({o_wreg, o_waddr, o_wdata} !== {1'b0, NopRegAddr, ZeroWord}) begin
            nerr++;
            $display("FAIL sh_wb got %b/%0d/%h want 0/0/0",
                     o_wreg, o_waddr, o_wdata);
        end
        nvec++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 32'h7FF ||
            obs_data[0] !== 8'hDD || obs_addr[1] !== 32'h800 ||
            obs_data[1] !== 8'hCC || obs_we[0] !== 1'b1) begin
            nerr++;
            $display("FAIL sh_bytes got %0d bytes %h@%h %h@%h want dd@7ff cc@800",
                     obs_addr.size(), obs_data[0], obs_addr[0],
                     obs_data[1], obs_addr[1]);
        end
        nvec++;
        if (o_unstable != 0) begin
            nerr++;
            $display("FAIL sh_stable got %0d changes want 0", o_unstable);
        end
    endtask

    task automatic test_reset_mid();
        aluop = ALU_LW_OP; alurslt = 32'h300; wreg_i = 1'b1;
        waddr_i = 5'd2; mem_ack = 1'b0;
        @(negedge dclk);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        @(negedge dclk);
        mem_ack = 1'b0;
        #1;
        nvec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h301) begin
            nerr++;
            $display("FAIL rstmid_pre got req=%b a=%h want 1/00000301",
                     mem_req, mem_addr);
        end
        rst = 1'b1;
        #1;
        nvec++;
        if (mem_req !== 1'b0 || stallreq !== 1'b0 || wreg_o !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_drop got req=%b st=%b w=%b want 0/0/0",
                     mem_req, stallreq, wreg_o);
        end
        @(negedge dclk);
        rst = 1'b0;
        run_op(ALU_ADD_OP, 32'h55, 32'h0, 1'b1, 5'd6, 0, 1'b0);
        nvec++;
        if ({o_stall, o_wreg, o_waddr, o_wdata} !==
            {32'd0, 1'b1, 5'd6, 32'h55}) begin
            nerr++;
            $display("FAIL rstmid_add got st=%0d %b/%0d/%h want 0 1/6/55",
                     o_stall, o_wreg, o_waddr, o_wdata);
        end
    endtask

    task automatic test_sw_wrap();
        logic [31:0] ea [4];
        ea[0] = 32'hFFFF_FFFE; ea[1] = 32'hFFFF_FFFF;
        ea[2] = 32'h0; ea[3] = 32'h1;
        run_op(ALU_SW_OP, 32'hFFFF_FFFE, 32'h0403_0201, 1'b1, 5'd1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (obs_addr.size() != 4 || obs_addr[i] !== ea[i] ||
                obs_data[i] !== 8'(i + 1)) begin
                nerr++;
                $display("FAIL wrap_byte%0d got %h@%h want %h@%h", i,
                         obs_data[i], obs_addr[i], 8'(i + 1), ea[i]);
            end
        end
    endtask

    task automatic test_random();
        alu_op_bus_t ops [10];
        alu_op_bus_t op;
        logic [31:0] base, sd, exp_w;
        logic [4:0] wa;
        logic wr;
        int ws, n, exp_st;
        ops[0] = ALU_ADD_OP; ops[1] = ALU_SUB_OP; ops[2] = ALU_LB_OP;
        ops[3] = ALU_LH_OP;  ops[4] = ALU_LW_OP;  ops[5] = ALU_LBU_OP;
        ops[6] = ALU_LHU_OP; ops[7] = ALU_SB_OP;  ops[8] = ALU_SH_OP;
        ops[9] = ALU_SW_OP;
        for (int t = 0; t < 60; t++) begin
            op = ops[$urandom_range(0, 9)];
            base = $urandom;
            if ($urandom_range(0, 3) == 0)
                base = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            sd = $urandom; wa = 5'($urandom); wr = 1'($urandom);
            ws = $urandom_range(0, 3);
            n = nbytes(op);
            exp_st = (n == 0) ? 0 : 1 + n * (ws + 1);
            if (is_load(op)) exp_w = ref_load(op, base);
            else if (is_store(op)) exp_w = ZeroWord;
            else exp_w = base;
            run_op(op, base, sd, wr, wa, ws, 1'b1);
            nvec++;
            if (o_stall != exp_st || !o_done || o_leak != 0 ||
                o_unstable != 0) begin
                nerr++;
                $display("FAIL rnd%0d_ctl op=%h got st=%0d lk=%0d un=%0d want st=%0d",
                         t, op, o_stall, o_leak, o_unstable, exp_st);
            end
            nvec++;
            if (is_store(op) ?
                ({o_wreg, o_waddr, o_wdata} !== {1'b0, NopRegAddr, ZeroWord}) :
                ({o_wreg, o_waddr, o_wdata} !== {wr, wa, exp_w})) begin
                nerr++;
                $display("FAIL rnd%0d_wb op=%h got %b/%0d/%h want data %h",
                         t, op, o_wreg, o_waddr, o_wdata, exp_w);
            end
            nvec++;
            if (obs_addr.size() != n) begin
                nerr++;
                $display("FAIL rnd%0d_cnt got %0d want %0d", t,
                         obs_addr.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    nvec++;
                    if (obs_addr[i] !== base + 32'(i) ||
                        obs_we[i] !== is_store(op) ||
                        (is_store(op) && obs_data[i] !== 8'(sd >> (8 * i))))
                    begin
                        nerr++;
                        $display("FAIL rnd%0d_b%0d got %h@%h we=%b want @%h",
                                 t, i, obs_data[i], obs_addr[i], obs_we[i],
                                 base + 32'(i));
                    end
                end
            end
        end
    endtask

    initial begin
        mem_ack = 1'b0; mem_rdata = 8'h00;
        test_reset();
        test_alu_pass();
        test_lw();
        test_lb_lbu();
        test_sh_wait();
        test_reset_mid();
        test_sw_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V pipeline, sitting downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It consumes the registered ALU op, ALU result (effective address or writeback value), and store data. For loads and stores it runs a multi-cycle byte-serial transfer on the byte-wide memory port, holding the pipeline via a stall request until the transfer completes. It then presents the writeback triple (wreg, waddr, wdata) to MEM/WB.

## Interface
Parameters: none. Constants come from `macro.vh`.

Ports:
- dclk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high. Clock is dclk.
- aluop_i  in  `AluOpBus`  op from EX/MEM.
- wreg_i  in  1  writeback enable from EX/MEM.
- waddr_i  in  5  destination register.
- alurslt_i  in  32  ALU result. It is the effective address for load/store ops.
- sdata_i  in  32  store data (rs2 value).
- mem_req_o  out  1  byte transfer request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  byte address.
- mem_wdata_o  out  8  write byte.
- mem_rdata_i  in  8  read byte. Valid on the edge where mem_ack_i = 1.
- mem_ack_i  in  1  transfer complete. Sampled on the rising edge of dclk.
- stallreq_o  out  1  request to the staller to hold EX/MEM and upstream stages.
- wreg_o  out  1  writeback enable to MEM/WB.
- waddr_o  out  5  writeback register.
- wdata_o  out  32  writeback data.

## Operation
- Memory ops: ALU_LB/LH/LW/LBU/LHU_OP and ALU_SB/SH/SW_OP. All other ops are non-memory.
- Non-memory op in IDLE:
  - wreg_o = wreg_i, waddr_o = waddr_i, wdata_o = alurslt_i, driven combinationally.
  - stallreq_o = 0 and mem_req_o = 0.
- FSM states are IDLE, ACCESS and DONE. A 2-bit byte counter k and a 32-bit assembly register are held alongside the state.
- IDLE with a memory op:
  - stallreq_o = 1 combinationally in the same cycle.
  - Next edge: go to ACCESS with k = 0 and the assembly register cleared.
- ACCESS:
  - Drive mem_req_o = 1, mem_addr_o = alurslt_i + k (mod 2^32), and mem_we_o = 1 for stores.
  - For stores, mem_wdata_o = sdata_i[8k+7:8k].
  - Byte count N is 1 for B/BU, 2 for H/HU and 4 for W.
  - On an edge with mem_ack_i = 1: for loads, capture mem_rdata_i into assembly bits [8k+7:8k] (little-endian).
    - If k = N-1, go to DONE.
    - Otherwise increment k.
  - Without ack: hold all request outputs stable.
  - stallreq_o = 1 throughout ACCESS.
- DONE, lasting one cycle:
  - stallreq_o = 0, mem_req_o = 0.
  - Loads: wreg_o = wreg_i, waddr_o = waddr_i, wdata_o = extended assembly.
    - LB sign-extends from bit 7, LH from bit 15.
    - LBU/LHU zero-extend; LW passes through.
  - Stores: wreg_o = 0, waddr_o = `NopRegAddr`, wdata_o = `ZeroWord`.
  - Next edge: go to IDLE unconditionally. The pipeline advances on that same edge.
- While stallreq_o = 1, wreg_o = 0, so MEM/WB never latches a partial result.
- No alignment check: misaligned H/W accesses simply touch consecutive byte addresses.
- Inputs are guaranteed stable while stallreq_o = 1, because EX/MEM holds under stall.

## Timing
- Reset value of every output:
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - stallreq_o = 0, wreg_o = 0, waddr_o = `NopRegAddr`, wdata_o = `ZeroWord`.
  - rst forces these regardless of inputs. State returns to IDLE, k = 0, assembly register = 0.
- Reset mid-ACCESS: mem_req_o drops immediately (asynchronous) and the transfer is abandoned, with no completion.
- Ack in the first request cycle is legal. Zero wait states give one byte per cycle.
- LW latency with zero wait states:
  - Cycle 0: IDLE detect, stall.
  - Cycles 1–4: ACCESS.
  - Cycle 5: DONE.
  - stallreq_o is high for 5 cycles. Each wait state adds one cycle.
- mem_ack_i while mem_req_o = 0 is ignored.
- Back-to-back memory ops: after DONE, the next op is detected in IDLE on the following cycle. There is no DONE→ACCESS shortcut.

## Structure
- `macro.vh` supplies:
  - `AluOpBus` and the ALU_*_OP codes, including the eight load/store codes and ALU_NOP_OP.
  - `Enable`, `Disable`, `ZeroWord` and `NopRegAddr`.
  - The state encodings, added as new constants.
- One sub-module, `load_extend`: a combinational block mapping (aluop, 32-bit assembly) to the extended 32-bit wdata.
- The FSM, counter and request muxing live in `mem_access`.

## Test plan
- ALU_ADD_OP, alurslt 0x0000_1234, wreg 1, waddr 5:
  - Same cycle: wdata_o = 0x1234, wreg_o = 1, stallreq_o = 0.
  - No mem_req_o ever.
- LW at 0x100, memory bytes 0x78, 0x56, 0x34, 0x12, ack every cycle:
  - Addresses 0x100–0x103 on cycles 1–4.
  - DONE on cycle 5 with wdata_o = 0x1234_5678 and stallreq_o low only on cycle 5.
- LB and LBU at 0x20 with byte 0x80:
  - LB gives wdata_o = 0xFFFF_FF80.
  - LBU gives 0x0000_0080.
- SH at 0x7FF, sdata 0xAABB_CCDD, ack delayed 2 cycles per byte:
  - Writes 0xDD@0x7FF then 0xCC@0x800, each held stable while waiting.
  - DONE has wreg_o = 0.
  - Total stall 7 cycles.
- rst asserted during the second byte of an LW:
  - mem_req_o and stallreq_o drop immediately.
  - After release, an ADD passes through normally.
- Address wrap: SW at 0xFFFF_FFFE writes bytes to 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 and 0x0000_0001.
